// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection mode controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package traffic_pkg;

    localparam logic [1:0] MODE_DAY   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    localparam logic [1:0] RESET_MODE = MODE_NIGHT;

    typedef enum logic [2:0] {
        S_DAY,
        S_NIGHT,
        S_PED,
        S_EMG,
        S_EMG_CLR
    } state_e;

    localparam state_e RESET_STATE = S_NIGHT;

    // Both emergency states present the same mode to the light sequencer.
    function automatic logic [1:0] mode_of(state_e s);
        case (s)
            S_DAY:   return MODE_DAY;
            S_NIGHT: return MODE_NIGHT;
            S_PED:   return MODE_PED;
            default: return MODE_EMG;
        endcase
    endfunction

endpackage

// File: rtl/traffic_mode_ctrl_if.sv
// Request inputs and mode outputs of the traffic mode controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface traffic_mode_ctrl_if #(
    parameter int NUM_EMG = 4,
    parameter int CNT_W   = 8
);
    logic               dayNightSignal;
    logic               pedSignal;
    logic [NUM_EMG-1:0] emgSignal;
    logic [1:0]         currentState;
    logic [NUM_EMG-1:0] emgGrant;
    logic               pedAck;
    logic               modeChange;
    logic [CNT_W-1:0]   dwellCount;

    // Request side: whoever drives the sensors/preemption inputs.
    modport master (
        output dayNightSignal, pedSignal, emgSignal,
        input  currentState, emgGrant, pedAck, modeChange, dwellCount
    );

    // Controller side.
    modport slave (
        input  dayNightSignal, pedSignal, emgSignal,
        output currentState, emgGrant, pedAck, modeChange, dwellCount
    );
endinterface

// File: rtl/emg_arbiter.sv
// Fixed lowest-index emergency arbiter; the current grant is held while its request stays high.
// Latency: grant registered, visible one cycle after the request edge.
// Backpressure: none; grant_switch_o flags a hand-over between two live channels for the coming edge.
module emg_arbiter #(
    parameter int NUM_EMG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EMG-1:0] req_i,
    output logic [NUM_EMG-1:0] grant_o,
    output logic               any_req_o,
    output logic               grant_switch_o
);

    logic [NUM_EMG-1:0] grant_q;
    logic [NUM_EMG-1:0] grant_d;
    logic [NUM_EMG-1:0] lowest;

    // One-hot of the lowest-index active request (zero when idle).
    always_comb begin
        lowest = '0;
        for (int i = NUM_EMG - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lowest    = '0;
                lowest[i] = 1'b1;
            end
        end
    end

    // Keep the lock while the owner still requests; otherwise re-arbitrate.
    always_comb begin
        grant_d = lowest;
        if ((req_i & grant_q) != '0) begin
            grant_d = grant_q;
        end
    end

    // Grant register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
        end else begin
            grant_q <= grant_d;
        end
    end

    assign grant_o        = grant_q;
    assign any_req_o      = |req_i;
    assign grant_switch_o = (grant_q != '0) && (grant_d != '0) && (grant_d != grant_q);

endmodule

// File: rtl/traffic_mode_ctrl.sv
// Intersection mode selector: emergency > pedestrian > day/night, with dwell timing and clearance.
// Latency: inputs sampled at one edge, resulting mode and pulses visible right after it.
// Backpressure: none; pedestrian requests are latched until served, emergencies preempt at once.
module traffic_mode_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_EMG   = 4,
    parameter int CNT_W     = 8,
    parameter int MIN_DWELL = 8,
    parameter int PED_HOLD  = 16,
    parameter int EMG_CLEAR = 4
) (
    input  logic                clk,
    input  logic                rst,
    traffic_mode_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] MIN_DWELL_M1 = CNT_W'(MIN_DWELL - 1);
    localparam logic [CNT_W-1:0] PED_HOLD_M1  = CNT_W'(PED_HOLD - 1);
    localparam logic [CNT_W-1:0] EMG_CLEAR_M1 = CNT_W'(EMG_CLEAR - 1);

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic               ped_pend_q, ped_pend_d;
    logic               ped_ack_q, ped_ack_d;
    logic               mode_chg_q, mode_chg_d;

    logic [NUM_EMG-1:0] grant;
    logic               any_req;
    logic               grant_switch;
    state_e             base_state;
    logic               dwell_met;

    emg_arbiter #(
        .NUM_EMG (NUM_EMG)
    ) u_emg_arbiter (
        .clk            (clk),
        .rst            (rst),
        .req_i          (bus.emgSignal),
        .grant_o        (grant),
        .any_req_o      (any_req),
        .grant_switch_o (grant_switch)
    );

    // Next-state selection; any emergency request wins over everything else.
    always_comb begin
        base_state = bus.dayNightSignal ? S_DAY : S_NIGHT;
        dwell_met  = (dwell_q >= MIN_DWELL_M1);
        state_d    = state_q;
        if (any_req) begin
            state_d = S_EMG;
        end else begin
            case (state_q)
                S_EMG:     state_d = S_EMG_CLR;
                S_EMG_CLR: if (dwell_q == EMG_CLEAR_M1) state_d = ped_pend_q ? S_PED : base_state;
                S_PED:     if (dwell_q == PED_HOLD_M1)  state_d = base_state;
                S_DAY: begin
                    if (dwell_met) begin
                        if (ped_pend_q)               state_d = S_PED;
                        else if (!bus.dayNightSignal) state_d = S_NIGHT;
                    end
                end
                S_NIGHT: begin
                    if (dwell_met) begin
                        if (ped_pend_q)              state_d = S_PED;
                        else if (bus.dayNightSignal) state_d = S_DAY;
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    // Derived outputs, pending-request latch and dwell counter for the coming edge.
    always_comb begin
        mode_d     = mode_of(state_d);
        mode_chg_d = (mode_d != mode_q);
        ped_ack_d  = (state_d == S_PED) && (state_q != S_PED);
        ped_pend_d = ped_pend_q;
        if (ped_ack_d) begin
            ped_pend_d = 1'b0;
        end else if (bus.pedSignal && (state_q != S_PED)) begin
            ped_pend_d = 1'b1;
        end
        // A grant hand-over restarts the dwell even though the state is unchanged.
        if ((state_d != state_q) || grant_switch) begin
            dwell_d = '0;
        end else if (dwell_q != '1) begin
            dwell_d = dwell_q + 1'b1;
        end else begin
            dwell_d = dwell_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            mode_q     <= RESET_MODE;
            dwell_q    <= '0;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
            mode_chg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            dwell_q    <= dwell_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_ack_d;
            mode_chg_q <= mode_chg_d;
        end
    end

    assign bus.currentState = mode_q;
    assign bus.emgGrant     = grant;
    assign bus.pedAck       = ped_ack_q;
    assign bus.modeChange   = mode_chg_q;
    assign bus.dwellCount   = dwell_q;

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// Directed plus short random bench for traffic_mode_ctrl with a scoreboard of predicted outputs.
// Latency: checks one cycle after each driven input set.
// Backpressure: n/a.
module tb_traffic_mode_ctrl;

    localparam int NUM_EMG   = 4;
    localparam int CNT_W     = 8;
    localparam int MIN_DWELL = 8;
    localparam int PED_HOLD  = 16;
    localparam int EMG_CLEAR = 4;

    localparam int ST_DAY   = 0;
    localparam int ST_NIGHT = 1;
    localparam int ST_PED   = 2;
    localparam int ST_EMG   = 3;
    localparam int ST_CLR   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dn  = 1'b1;
    logic       ped = 1'b0;
    logic [3:0] emg = 4'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state.
    int       m_state;
    logic [3:0] m_grant;
    int       m_dwell;
    bit       m_pend;
    bit       m_ack;
    bit       m_chg;

    logic [15:0] sb_q[$];

    traffic_mode_ctrl_if #(.NUM_EMG(NUM_EMG), .CNT_W(CNT_W)) bus ();

    assign bus.dayNightSignal = dn;
    assign bus.pedSignal      = ped;
    assign bus.emgSignal      = emg;

    traffic_mode_ctrl #(
        .NUM_EMG   (NUM_EMG),
        .CNT_W     (CNT_W),
        .MIN_DWELL (MIN_DWELL),
        .PED_HOLD  (PED_HOLD),
        .EMG_CLEAR (EMG_CLEAR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int mode_of(int s);
        if (s == ST_DAY)   return 0;
        if (s == ST_NIGHT) return 1;
        if (s == ST_PED)   return 2;
        return 3;
    endfunction

    function automatic logic [15:0] pack_model();
        return {2'(mode_of(m_state)), m_grant, m_ack, m_chg, 8'(m_dwell)};
    endfunction

    task automatic model_reset();
        m_state = ST_NIGHT;
        m_grant = 4'b0;
        m_dwell = 0;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
        m_chg   = 1'b0;
        sb_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int         ns;
        logic [3:0] ng;
        bit         sw;
        int         base;
        base = dn ? ST_DAY : ST_NIGHT;
        ng   = 4'b0;
        if ((m_grant & emg) != 4'b0) ng = m_grant;
        else for (int i = 3; i >= 0; i--) if (emg[i]) ng = 4'b0001 << i;
        sw = (m_grant != 4'b0) && (ng != 4'b0) && (ng != m_grant);
        ns = m_state;
        if (emg != 4'b0) ns = ST_EMG;
        else if (m_state == ST_EMG) ns = ST_CLR;
        else if (m_state == ST_CLR) begin
            if (m_dwell == EMG_CLEAR - 1) ns = m_pend ? ST_PED : base;
        end else if (m_state == ST_PED) begin
            if (m_dwell == PED_HOLD - 1) ns = base;
        end else if (m_dwell >= MIN_DWELL - 1) begin
            if (m_pend) ns = ST_PED;
            else if (base != m_state) ns = base;
        end
        m_ack = (ns == ST_PED) && (m_state != ST_PED);
        m_chg = mode_of(ns) != mode_of(m_state);
        if (m_ack) m_pend = 1'b0;
        else if (ped && m_state != ST_PED) m_pend = 1'b1;
        if (ns != m_state || sw) m_dwell = 0;
        else if (m_dwell < 255) m_dwell = m_dwell + 1;
        m_state = ns;
        m_grant = ng;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Predict, push, clock, then pop and compare the full output snapshot.
    task automatic tick();
        logic [15:0] exp;
        logic [15:0] obs;
        model_step();
        sb_q.push_back(pack_model());
        @(posedge clk);
        #1;
        cyc++;
        exp = sb_q.pop_front();
        obs = {bus.currentState, bus.emgGrant, bus.pedAck, bus.modeChange, bus.dwellCount};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL scoreboard cyc=%0d observed=%0h expected=%0h", cyc, obs, exp);
        end
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic tick_until(int tgt, int limit, string tag);
        int n;
        n = 0;
        while (m_state != tgt && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.currentState), 32'(mode_of(tgt)));
    endtask

    initial begin
        // 1. reset and NIGHT -> DAY after the minimum dwell
        #2 rst = 1'b1;
        #2;
        chk("rst_mode",  32'(bus.currentState), 32'd1);
        chk("rst_grant", 32'(bus.emgGrant),     32'd0);
        chk("rst_ack",   32'(bus.pedAck),       32'd0);
        chk("rst_chg",   32'(bus.modeChange),   32'd0);
        chk("rst_dwell", 32'(bus.dwellCount),   32'd0);
        #8 rst = 1'b0;
        model_reset();
        ticks(7);
        chk("night_hold", 32'(bus.currentState), 32'd1);
        tick();
        chk("to_day",     32'(bus.currentState), 32'd0);
        chk("to_day_chg", 32'(bus.modeChange),   32'd1);
        chk("day_dwell0", 32'(bus.dwellCount),   32'd0);

        // 2. latched pedestrian request served once dwell is met
        ticks(3);
        ped = 1'b1; tick(); ped = 1'b0;
        ticks(3);
        chk("ped_wait_mode",  32'(bus.currentState), 32'd0);
        chk("ped_wait_dwell", 32'(bus.dwellCount),   32'd7);
        tick();
        chk("ped_enter", 32'(bus.currentState), 32'd2);
        chk("ped_ack",   32'(bus.pedAck),       32'd1);
        chk("ped_chg",   32'(bus.modeChange),   32'd1);
        ticks(15);
        chk("ped_hold", 32'(bus.currentState), 32'd2);
        tick();
        chk("ped_exit", 32'(bus.currentState), 32'd0);

        // 3. preemption of PED, grant lock and hand-over
        ped = 1'b1; tick(); ped = 1'b0;
        tick_until(ST_PED, 30, "ped_again");
        ticks(5);
        emg = 4'b0110; tick();
        chk("emg_mode",  32'(bus.currentState), 32'd3);
        chk("emg_grant", 32'(bus.emgGrant),     32'h2);
        emg = 4'b0111; tick();
        chk("emg_lock", 32'(bus.emgGrant), 32'h2);
        emg = 4'b0101; tick();
        chk("emg_switch",     32'(bus.emgGrant),   32'h1);
        chk("emg_switch_chg", 32'(bus.modeChange), 32'd0);
        chk("emg_switch_dw",  32'(bus.dwellCount), 32'd0);

        // 4. clearance then base mode; again with a pedestrian request pending
        emg = 4'b0; tick();
        chk("clr_grant", 32'(bus.emgGrant),     32'd0);
        chk("clr_mode",  32'(bus.currentState), 32'd3);
        ticks(3);
        chk("clr_hold", 32'(bus.currentState), 32'd3);
        dn = 1'b0; tick();
        chk("clr_to_night", 32'(bus.currentState), 32'd1);
        emg = 4'b0001; tick();
        ped = 1'b1; tick(); ped = 1'b0;
        emg = 4'b0; tick();
        ticks(3);
        tick();
        chk("clr_to_ped",  32'(bus.currentState), 32'd2);
        chk("clr_ped_ack", 32'(bus.pedAck),       32'd1);

        // 5. re-entry into emergency during clearance
        dn = 1'b1;
        tick_until(ST_DAY, 40, "back_day");
        emg = 4'b0001; tick();
        emg = 4'b0; tick();
        ticks(2);
        emg = 4'b1000; tick();
        chk("reemg_mode",  32'(bus.currentState), 32'd3);
        chk("reemg_grant", 32'(bus.emgGrant),     32'h8);
        chk("reemg_chg",   32'(bus.modeChange),   32'd0);
        emg = 4'b0;
        tick_until(ST_DAY, 10, "reemg_exit");

        // 6. asynchronous reset in the middle of PED
        ped = 1'b1; tick(); ped = 1'b0;
        tick_until(ST_PED, 20, "ped_pre_rst");
        ticks(3);
        #3 rst = 1'b1;
        #1;
        chk("arst_mode",  32'(bus.currentState), 32'd1);
        chk("arst_grant", 32'(bus.emgGrant),     32'd0);
        chk("arst_dwell", 32'(bus.dwellCount),   32'd0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        ticks(MIN_DWELL);
        chk("post_rst_day", 32'(bus.currentState), 32'd0);

        // Short random run against the model.
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 9) == 0)
                emg = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            ped = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) dn = ~dn;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/traffic_mode_ctrl.md
Name: traffic_mode_ctrl

Overview:
Parametrised successor to the 2-bit traffic mode register. Selects the intersection mode (day, night, pedestrian, emergency) with a fixed priority order:
- emergency, then pedestrian, then day/night.

Beyond the original register, it adds:
- minimum-dwell timing on each mode;
- latched pedestrian requests;
- a multi-channel emergency arbiter with grant lock;
- a post-emergency clearance interval.

Feeds the light-sequencing logic downstream.

Parameters:
NUM_EMG, 4, number of emergency request channels (>=1)
CNT_W, 8, dwell counter width
MIN_DWELL, 8, minimum cycles in DAY/NIGHT before a non-emergency transition (1..2^CNT_W-1)
PED_HOLD, 16, exact cycles spent in PED (1..2^CNT_W-1)
EMG_CLEAR, 4, cycles of clearance after the last emergency releases (1..2^CNT_W-1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
dayNightSignal  input  1  1 = day, 0 = night
pedSignal  input  1  pedestrian request, any-length pulse
emgSignal  input  NUM_EMG  per-channel emergency request, level
currentState  output  2  00 day, 01 night, 10 pedestrian, 11 emergency
emgGrant  output  NUM_EMG  one-hot granted channel, 0 when none
pedAck  output  1  1-cycle pulse on entry to PED
modeChange  output  1  1-cycle pulse when currentState changes value
dwellCount  output  CNT_W  cycles since entry to current internal state, saturating

Behaviour:
- Internal states: S_DAY, S_NIGHT, S_PED, S_EMG, S_EMG_CLR.
- Output mapping: S_DAY=00, S_NIGHT=01, S_PED=10, S_EMG and S_EMG_CLR=11.
- Reset (async, immediate): state S_NIGHT (currentState=01), emgGrant=0, pedAck=0, modeChange=0, dwellCount=0, pedPending=0.
- Timing: all outputs registered. Inputs sampled at edge N; the resulting state is visible after edge N.
- dwellCount:
  - cleared to 0 on every state entry and on every emgGrant switch;
  - otherwise increments, saturating at 2^CNT_W-1.
- "Dwell met": dwellCount >= MIN_DWELL-1.
- pedPending:
  - set when pedSignal=1 and state is not S_PED;
  - cleared on entry to S_PED;
  - pedSignal while in S_PED is ignored.
- Emergency preemption:
  - any emgSignal bit high in S_DAY, S_NIGHT, S_PED or S_EMG_CLR forces S_EMG next cycle, regardless of dwell;
  - grant goes to the lowest-index active bit;
  - a preempted PED is abandoned; pedPending is not re-set by it.
- S_EMG:
  - grant is locked while the granted bit stays high; higher-priority arrivals do not steal it.
  - When the granted bit drops and other bits are high: grant moves to the lowest-index active bit next cycle. State stays S_EMG, dwellCount restarts, no modeChange pulse.
  - When the granted bit drops and no bits are high: go to S_EMG_CLR, emgGrant=0.
- S_EMG_CLR:
  - after EMG_CLEAR cycles (dwellCount == EMG_CLEAR-1), exit to S_PED if pedPending, else to the base mode;
  - base mode is S_DAY if dayNightSignal=1, else S_NIGHT.
- S_DAY / S_NIGHT (no emergency active):
  - if pedPending and dwell met: go to S_PED;
  - else if dayNightSignal disagrees with the current mode and dwell met: switch to the other mode;
  - otherwise hold.
- S_PED: exit after exactly PED_HOLD cycles (dwellCount == PED_HOLD-1) to the base mode, subject to emergency preemption.
- modeChange: asserted in the first cycle a new currentState value is visible. Not asserted for S_EMG->S_EMG_CLR or for grant switches.
- pedAck: asserted in the first cycle of S_PED.
- Simultaneous events: emergency beats pedestrian, and pedestrian beats day/night on the same edge.

Decomposition:
- Shared package traffic_pkg holds:
  - mode encodings MODE_DAY/MODE_NIGHT/MODE_PED/MODE_EMG;
  - internal state enum;
  - reset mode constant (MODE_NIGHT).
- One sub-module: emg_arbiter. It is a NUM_EMG-wide fixed lowest-index priority arbiter with grant lock. It outputs grant, any_req, and a grant_switch pulse.

Test Plan:
1. Reset, dayNightSignal=1 held -> currentState=01 after reset; 00 after 8 cycles (MIN_DWELL) with a modeChange pulse; dwellCount then restarts from 0.
2. In S_DAY with dwellCount=3, pulse pedSignal one cycle -> stays 00 until dwellCount reaches 7. Then 10 with pedAck and modeChange pulses. Stays 10 for exactly 16 cycles, then 00.
3. In S_PED at dwellCount=5, emgSignal=4'b0110 -> next cycle currentState=11, emgGrant=0010. Raise bit 0 meanwhile -> grant stays 0010. Drop bit 1 -> emgGrant=0001, no modeChange.
4. Release all emergency bits -> emgGrant=0000, currentState stays 11 for 4 cycles. Then base mode per dayNightSignal (pedPending=0). Repeat with pedSignal pulsed during S_EMG -> exits to 10.
5. During S_EMG_CLR cycle 2, assert emgSignal=4'b1000 -> next cycle S_EMG with emgGrant=1000 and no modeChange pulse.
6. Assert rst mid-PED at a non-edge time -> currentState=01 and emgGrant=0 immediately, pedPending cleared; normal operation resumes after deassert.
